// File: rtl/regfile_mp_if.sv
// Bus interface between decode/writeback and regfile_mp.
// The parity signals exist only when REGF_PARITY_EN is defined.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                         clr_req;
  logic                         busy;
  logic                         we;
  logic [AW-1:0]                waddr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic [NUM_RD*AW-1:0]         raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_REGS-1:0]          dirty;
`ifdef REGF_PARITY_EN
  logic                         par_inj;
  logic [NUM_RD-1:0]            rd_perr;
`endif

  modport master (
    output clr_req, we, waddr, wdata, raddr,
`ifdef REGF_PARITY_EN
    output par_inj,
    input  rd_perr,
`endif
    input  busy, rdata, dirty
  );

  modport slave (
    input  clr_req, we, waddr, wdata, raddr,
`ifdef REGF_PARITY_EN
    input  par_inj,
    output rd_perr,
`endif
    output busy, rdata, dirty
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardware clear, write bypass and dirty bits.
// Optional per-entry even parity with error injection when REGF_PARITY_EN is defined.
//
// state    | meaning
// ST_CLEAR | sequencer zeroing mem[clr_ptr], busy=1, reads forced 0
// ST_READY | normal read/write operation
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                st_q, st_d;
  logic [AW-1:0]         clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   dirty_q;
  logic                  wr_valid, wr_fire, clr_go;
  logic [AW-1:0]         ra;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_c;
  logic [NUM_RD-1:0]     perr_c;

  assign wr_valid = bus.we && (int'(bus.waddr) < NUM_REGS) &&
                    !((ZERO_REG != 0) && (bus.waddr == '0));
  assign clr_go   = (st_q == ST_READY) && bus.clr_req;
  assign wr_fire  = (st_q == ST_READY) && !bus.clr_req && wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      st_q      <= st_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    clr_ptr_d = clr_ptr_q;
    case (st_q)
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          st_d      = ST_READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.clr_req) begin
          st_d      = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: st_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    bus.busy = (st_q == ST_CLEAR);
  end

  // Storage is never reset directly; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (st_q == ST_CLEAR)
        mem_q[clr_ptr_q] <= '0;
      else if (wr_fire)
        mem_q[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_go)
      dirty_q <= '0;
    else if (wr_fire)
      dirty_q[bus.waddr] <= 1'b1;
  end

  assign bus.dirty = dirty_q;

`ifdef REGF_PARITY_EN
  logic par_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (st_q == ST_CLEAR)
        par_q[clr_ptr_q] <= 1'b0;
      else if (wr_fire)
        par_q[bus.waddr] <= (^bus.wdata) ^ bus.par_inj;
    end
  end

  assign bus.rd_perr = perr_c;
`endif

  always_comb begin
    rdata_c = '0;
    perr_c  = '0;
    ra      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.raddr[i*AW +: AW];
      if ((st_q == ST_READY) && (int'(ra) < NUM_REGS) &&
          !((ZERO_REG != 0) && (ra == '0))) begin
        if (wr_fire && (bus.waddr == ra)) begin
          rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
        end else begin
          rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
`ifdef REGF_PARITY_EN
          perr_c[i] = par_q[ra] ^ (^mem_q[ra]);
`endif
        end
      end
    end
  end

  assign bus.rdata = rdata_c;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: a default 32-entry instance and a 24-entry ZERO_REG=0 instance.
module tb_regfile_mp;
  logic clk, rst, rst24;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt32, cnt24;

  regfile_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(2)) bus0 ();
  regfile_mp_if #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_RD(2)) bus24 ();

  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1))
    dut (.clk(clk), .rst(rst), .bus(bus0.slave));
  regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_RD(2), .ZERO_REG(0))
    dut24 (.clk(clk), .rst(rst24), .bus(bus24.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst24 = 1'b1;
    bus0.clr_req = 0; bus0.we = 0; bus0.waddr = '0; bus0.wdata = '0; bus0.raddr = '0;
    bus24.clr_req = 0; bus24.we = 0; bus24.waddr = '0; bus24.wdata = '0; bus24.raddr = '0;
`ifdef REGF_PARITY_EN
    bus0.par_inj = 0; bus24.par_inj = 0;
`endif

    // reset and initial clear
    tick(); tick();
    bus0.raddr = {5'd31, 5'd5};
    #1;
    check("rst_busy", bus0.busy, 1);
    check("rst_dirty", bus0.dirty, 0);
    check("rst_rdata", bus0.rdata, 0);
    rst = 1'b0; rst24 = 1'b0;
    cnt32 = 0; cnt24 = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k == 3) check("clr_rdata", bus0.rdata, 0);
      if (cnt32 == 0 && !bus0.busy) cnt32 = k + 1;
      if (cnt24 == 0 && !bus24.busy) cnt24 = k + 1;
      if (cnt32 != 0 && cnt24 != 0) break;
    end
    check("busy_len32", cnt32, 32);
    check("busy_len24", cnt24, 24);
    check("post_clr_dirty", bus0.dirty, 0);
    check("post_clr_rdata", bus0.rdata, 0);

    // write with same-cycle bypass, then dual-port read
    bus0.we = 1; bus0.waddr = 5'd5; bus0.wdata = 32'hDEADBEEF; bus0.raddr = {5'd1, 5'd5};
    #1;
    check("bypass_r5", bus0.rdata[31:0], 32'hDEADBEEF);
    check("no_bypass_r1", bus0.rdata[63:32], 0);
    tick();
    bus0.we = 0; bus0.raddr = {5'd5, 5'd5};
    #1;
    check("rd0_r5", bus0.rdata[31:0], 32'hDEADBEEF);
    check("rd1_r5", bus0.rdata[63:32], 32'hDEADBEEF);
    check("dirty_r5", bus0.dirty, 64'h20);

    // register 0 behaviour on both instances
    bus0.we = 1; bus0.waddr = 0; bus0.wdata = 32'h1234; bus0.raddr = '0;
    bus24.we = 1; bus24.waddr = 0; bus24.wdata = 32'h1234; bus24.raddr = '0;
    #1;
    check("zr_bypass", bus0.rdata[31:0], 0);
    check("nz_bypass", bus24.rdata[31:0], 32'h1234);
    tick();
    bus0.we = 0; bus24.we = 0;
    #1;
    check("zr_read", bus0.rdata[31:0], 0);
    check("zr_dirty", bus0.dirty, 64'h20);
    check("nz_read", bus24.rdata[31:0], 32'h1234);
    check("nz_dirty", bus24.dirty, 64'h1);

    // clear request drops concurrent write; writes ignored while busy
    bus0.we = 1; bus0.waddr = 5'd7; bus0.wdata = 32'hA5;
    tick();
    bus0.waddr = 5'd9; bus0.wdata = 32'h77; bus0.clr_req = 1;
    tick();
    bus0.clr_req = 0; bus0.wdata = 32'h55; bus0.raddr = {5'd9, 5'd7};
    #1;
    check("clr_busy", bus0.busy, 1);
    check("clr_dirty", bus0.dirty, 0);
    check("clr_rd_forced0", bus0.rdata, 0);
    cnt32 = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!bus0.busy) begin
        cnt32 = k + 1;
        break;
      end
    end
    bus0.we = 0;
    #1;
    check("clr_len", cnt32, 32);
    check("clr_r7", bus0.rdata[31:0], 0);
    check("clr_r9", bus0.rdata[63:32], 0);
    check("clr_dirty_end", bus0.dirty, 0);

    // out-of-range address on the 24-entry instance, last valid entry
    bus24.we = 1; bus24.waddr = 5'd30; bus24.wdata = 32'hCAFE; bus24.raddr = {5'd23, 5'd30};
    #1;
    check("oor_bypass", bus24.rdata[31:0], 0);
    tick();
    bus24.waddr = 5'd23; bus24.wdata = 32'h0BAD_F00D;
    #1;
    check("oor_dirty", bus24.dirty, 64'h1);
    check("oor_read", bus24.rdata[31:0], 0);
    tick();
    bus24.we = 0;
    #1;
    check("last_read", bus24.rdata[63:32], 32'h0BAD_F00D);
    check("last_dirty", bus24.dirty, 64'h80_0001);

    // reset in the middle of a clear restarts the sequence
    rst24 = 1;
    tick();
    rst24 = 0;
    for (int k = 0; k < 10; k++) tick();
    check("mid_busy", bus24.busy, 1);
    rst24 = 1;
    tick();
    rst24 = 0;
    cnt24 = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!bus24.busy) begin
        cnt24 = k + 1;
        break;
      end
    end
    check("restart_len", cnt24, 24);
    check("restart_r23", bus24.rdata[63:32], 0);
    check("restart_dirty", bus24.dirty, 0);

`ifdef REGF_PARITY_EN
    bus0.we = 1; bus0.waddr = 5'd3; bus0.wdata = 32'h1; bus0.par_inj = 1; bus0.raddr = {5'd0, 5'd3};
    #1;
    check("perr_bypass", bus0.rd_perr, 0);
    tick();
    bus0.we = 0; bus0.par_inj = 0;
    #1;
    check("perr_inj", bus0.rd_perr, 2'b01);
    bus0.we = 1;
    tick();
    bus0.we = 0;
    #1;
    check("perr_clean", bus0.rd_perr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
